button_debounce: RTL and testbench

- Multi-channel debouncer that sits directly upstream of the button edge detectors. Board push-buttons feed it, and its clean level outputs drive the edge-detect stage.
- Per channel: 2-FF synchroniser, then a counter-qualified 4-state FSM.
- Outputs per channel: a stable level, plus one-cycle press and release strobes. These let the FIFO push/pop logic consume clean, glitch-free events.

---
 rtl/button_debounce_if.sv | 21 ++
 rtl/button_debounce.sv | 153 +++++++++++++++
 tb/tb_button_debounce.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// Button bus: raw inputs in, debounced level and event strobes out.
// master drives the raw buttons; slave is the debouncer.
interface button_debounce_if #(
   parameter int unsigned NUM_BTNS = 2
);
   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] btn_level;
   logic [NUM_BTNS-1:0] btn_press;
   logic [NUM_BTNS-1:0] btn_release;
   logic [NUM_BTNS-1:0] btn_long;

   modport master (
      output btn_raw,
      input  btn_level, btn_press, btn_release, btn_long
   );

   modport slave (
      input  btn_raw,
      output btn_level, btn_press, btn_release, btn_long
   );
endinterface

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: 2-FF sync + counter-qualified FSM per channel.
// Optional long-press strobe enabled by defining BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
   parameter int unsigned NUM_BTNS          = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = 500000,
   parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
   input  logic               clk,
   input  logic               reset_n,
   button_debounce_if.slave   btn_if
);

   if (NUM_BTNS < 1 || DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_cfg
      $error("button_debounce: NUM_BTNS, DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
   end

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      STABLE_LOW,
      CHECK_HIGH,
      STABLE_HIGH,
      CHECK_LOW
   } state_t;

   logic [NUM_BTNS-1:0] r_sync1;
   logic [NUM_BTNS-1:0] r_sync2;
   state_t              r_state [NUM_BTNS];
   logic [CW-1:0]       r_cnt   [NUM_BTNS];
   logic [NUM_BTNS-1:0] r_level;
   logic [NUM_BTNS-1:0] r_press;
   logic [NUM_BTNS-1:0] r_release;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_if.btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Strobes default low every cycle; only a STABLE_* entry raises one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            r_state[i] <= STABLE_LOW;
            r_cnt[i]   <= '0;
         end
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            r_press[i]   <= 1'b0;
            r_release[i] <= 1'b0;
            case (r_state[i])
               STABLE_LOW: begin
                  if (r_sync2[i]) begin
                     r_state[i] <= CHECK_HIGH;
                     r_cnt[i]   <= CNT_ONE;
                  end else begin
                     r_cnt[i]   <= '0;
                  end
               end
               CHECK_HIGH: begin
                  if (!r_sync2[i]) begin
                     r_state[i] <= STABLE_LOW;
                     r_cnt[i]   <= '0;
                  end else if (r_cnt[i] == CNT_MAX) begin
                     r_state[i] <= STABLE_HIGH;
                     r_cnt[i]   <= '0;
                     r_level[i] <= 1'b1;
                     r_press[i] <= 1'b1;
                  end else begin
                     r_cnt[i]   <= r_cnt[i] + CNT_ONE;
                  end
               end
               STABLE_HIGH: begin
                  if (!r_sync2[i]) begin
                     r_state[i] <= CHECK_LOW;
                     r_cnt[i]   <= CNT_ONE;
                  end else begin
                     r_cnt[i]   <= '0;
                  end
               end
               CHECK_LOW: begin
                  if (r_sync2[i]) begin
                     r_state[i] <= STABLE_HIGH;
                     r_cnt[i]   <= '0;
                  end else if (r_cnt[i] == CNT_MAX) begin
                     r_state[i]   <= STABLE_LOW;
                     r_cnt[i]     <= '0;
                     r_level[i]   <= 1'b0;
                     r_release[i] <= 1'b1;
                  end else begin
                     r_cnt[i]     <= r_cnt[i] + CNT_ONE;
                  end
               end
               default: begin
                  r_state[i] <= STABLE_LOW;
                  r_cnt[i]   <= '0;
               end
            endcase
         end
      end
   end

   assign btn_if.btn_level   = r_level;
   assign btn_if.btn_press   = r_press;
   assign btn_if.btn_release = r_release;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_PRESS_CYCLES);
   localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_PRESS_CYCLES - 1);
   localparam logic [LW-1:0] HOLD_ONE  = LW'(1);

   logic [LW-1:0]       r_hold [NUM_BTNS];
   logic [NUM_BTNS-1:0] r_long;

   // Pulse is registered off the pre-increment count so it lands exactly
   // LONG_PRESS_CYCLES cycles after btn_press; saturation keeps it single.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            r_hold[i] <= '0;
         end
         r_long <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            if (!r_level[i]) begin
               r_hold[i] <= '0;
               r_long[i] <= 1'b0;
            end else if (r_hold[i] != HOLD_MAX) begin
               r_hold[i] <= r_hold[i] + HOLD_ONE;
               r_long[i] <= (r_hold[i] == HOLD_LAST);
            end else begin
               r_long[i] <= 1'b0;
            end
         end
      end
   end

   assign btn_if.btn_long = r_long;
`else
   assign btn_if.btn_long = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected strobe events,
// a negedge monitor pops and compares whenever any strobe is presented.
module tb_button_debounce;

   localparam int unsigned NB  = 2;
   localparam int unsigned DEB = 4;
   localparam int unsigned LP  = 20;
   // Raw driven at a negedge with cycle count c is first sampled at edge c+1.
   localparam int unsigned LAT = DEB + 3;

   typedef struct packed {
      int unsigned cyc;
      logic [1:0]  press;
      logic [1:0]  rel;
      logic [1:0]  lng;
      logic [1:0]  level;
   } exp_t;

   logic        clk;
   logic        reset_n;
   int unsigned cyc;
   int unsigned n_checks;
   int unsigned n_fail;
   exp_t        q[$];
   exp_t        e;

   button_debounce_if #(.NUM_BTNS(NB)) bus ();

   button_debounce #(
      .NUM_BTNS(NB),
      .DEBOUNCE_CYCLES(DEB),
      .LONG_PRESS_CYCLES(LP)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .btn_if(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int unsigned at, input logic [1:0] p, input logic [1:0] r,
                       input logic [1:0] l, input logic [1:0] lv);
      exp_t x;
      x.cyc = at; x.press = p; x.rel = r; x.lng = l; x.level = lv;
      q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (reset_n && (bus.btn_press | bus.btn_release | bus.btn_long) !== 2'b00) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: press=%b release=%b long=%b, expected none (cycle %0d)",
                     bus.btn_press, bus.btn_release, bus.btn_long, cyc);
         end else begin
            e = q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("btn_press", {30'd0, bus.btn_press}, {30'd0, e.press});
            chk("btn_release", {30'd0, bus.btn_release}, {30'd0, e.rel});
            chk("btn_long", {30'd0, bus.btn_long}, {30'd0, e.lng});
            chk("btn_level", {30'd0, bus.btn_level}, {30'd0, e.level});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset with both buttons held
      reset_n = 1'b0;
      bus.btn_raw = 2'b11;
      step(3);
      chk("reset_level", {30'd0, bus.btn_level}, 32'd0);
      chk("reset_press", {30'd0, bus.btn_press}, 32'd0);
      chk("reset_release", {30'd0, bus.btn_release}, 32'd0);
      chk("reset_long", {30'd0, bus.btn_long}, 32'd0);
      reset_n = 1'b1;
      push(cyc + LAT, 2'b11, 2'b00, 2'b00, 2'b11);
      step(8);
      bus.btn_raw = 2'b00;
      push(cyc + LAT, 2'b00, 2'b11, 2'b00, 2'b00);
      step(10);

      // Clean press / release on ch0
      bus.btn_raw = 2'b01;
      push(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
      step(10);
      bus.btn_raw = 2'b00;
      push(cyc + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
      step(10);

      // Bounce on ch0, then a final rise that is held
      bus.btn_raw = 2'b01; step(2);
      bus.btn_raw = 2'b00; step(2);
      bus.btn_raw = 2'b01; step(2);
      bus.btn_raw = 2'b00; step(2);
      bus.btn_raw = 2'b01;
      push(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
      step(10);

      // Independence: opposite events on the two channels on the same edge
      bus.btn_raw = 2'b10;
      push(cyc + LAT, 2'b10, 2'b01, 2'b00, 2'b10);
      step(10);
      bus.btn_raw = 2'b01;
      push(cyc + LAT, 2'b01, 2'b10, 2'b00, 2'b01);
      step(10);
      bus.btn_raw = 2'b00;
      push(cyc + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
      step(10);

      // Reset mid-check: ch1 settled high, ch0 pending in CHECK_HIGH
      bus.btn_raw = 2'b10;
      push(cyc + LAT, 2'b10, 2'b00, 2'b00, 2'b10);
      step(10);
      bus.btn_raw = 2'b11;
      step(3);
      reset_n = 1'b0;
      #1;
      chk("async_reset_level", {30'd0, bus.btn_level}, 32'd0);
      chk("async_reset_press", {30'd0, bus.btn_press}, 32'd0);
      chk("async_reset_release", {30'd0, bus.btn_release}, 32'd0);
      chk("async_reset_long", {30'd0, bus.btn_long}, 32'd0);
      bus.btn_raw = 2'b00;
      step(3);
      reset_n = 1'b1;
      step(12);

      // Long hold on ch0, then a short hold that must not reach the long threshold
      bus.btn_raw = 2'b01;
      push(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      push(cyc + LAT + LP, 2'b00, 2'b00, 2'b01, 2'b01);
`endif
      step(LAT + 30);
      bus.btn_raw = 2'b00;
      push(cyc + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
      step(10);
      bus.btn_raw = 2'b01;
      push(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
      step(15);
      bus.btn_raw = 2'b00;
      push(cyc + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
      step(40);

      chk("scoreboard_drained", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
